burst_cycle_controller: RTL and testbench
=========================================

// Module: burst_cycle_controller
// PURPOSE
//  Burst-mode sequencer for the waveform generator; drives the 20-bit burst amount counter
//  (Cnt_EN / Cnt_Clr_n) and reads its registered SUM_OUT back on Sum_In.
//  On trigger it waits a programmable delay, then gates the waveform (Wave_Gate) for exactly
//  Burst_N waveform cycles, counted on Cycle_Wrap pulses from the phase accumulator.
// PARAMETERS
//  CNT_W  20  burst count width; must match the amount counter
//  DLY_W  16  trigger-delay counter width
// PORTS
//  Clock       in   1      system clock; all logic on posedge
//  Reset       in   1      synchronous, active-low
//  Trigger     in   1      burst trigger; level input, rising edge detected internally
//  Stop        in   1      abort; active high, sampled every cycle
//  Burst_N     in   CNT_W  cycles per burst; latched on trigger accept
//  Trig_Delay  in   DLY_W  extra delay cycles before gating; latched on trigger accept
//  Cycle_Wrap  in   1      1-clock pulse per completed waveform cycle
//  Sum_In      in   CNT_W  amount counter SUM_OUT (2-clock latency from Cnt_EN)
//  Cnt_EN      out  1      counter increment, 1-clock pulse
//  Cnt_Clr_n   out  1      counter clear, active low; AND with system reset at top level
//  Wave_Gate   out  1      1 = waveform output enabled
//  Busy        out  1      1 = any state other than IDLE
//  Done        out  1      1-clock pulse on normal burst completion
//  Trig_Ign    out  1      1-clock pulse when a trigger edge is rejected
// BEHAVIOUR
//  - All outputs registered. On Reset=0: state IDLE; Cnt_EN=0, Cnt_Clr_n=1, Wave_Gate=0,
//    Busy=0, Done=0, Trig_Ign=0; edge detector prev=0; latched N/delay = 0.
//  - Trigger edge = Trigger & ~prev (prev registered each clock).
//  - States: IDLE, DELAY, BURST, FLUSH.
//  - IDLE: on an edge at cycle t with Burst_N != 0:
//    - latch Burst_N and Trig_Delay;
//    - t+1: DELAY, Busy=1, Cnt_Clr_n=0 for exactly one cycle.
//  - DELAY: lasts exactly Trig_Delay+2 cycles; the 2-cycle minimum flushes counter latency,
//    so Sum_In=0 on entering BURST. Then BURST with Wave_Gate=1 in the same cycle.
//  - BURST, on Cycle_Wrap:
//    - Cnt_EN=1 on the next cycle;
//    - if Sum_In == N_lat-1, also Wave_Gate=0 on that next cycle and go to FLUSH.
//  - FLUSH: wait until Sum_In == N_lat; then Done=1 for one cycle, Busy=0, go to IDLE.
//    Cycle_Wrap is ignored in FLUSH.
//  - Stop=1 in DELAY/BURST/FLUSH: next cycle IDLE, Wave_Gate=0, Busy=0, Cnt_EN=0, no Done.
//    Stop has priority over a simultaneous Cycle_Wrap (that wrap is not counted).
//  - Trigger edge while Busy=1, or Burst_N==0 without macro: Trig_Ign=1 next cycle,
//    state unchanged.
//  - Constraint: Cycle_Wrap pulses at least 4 clocks apart, so Sum_In is current at each
//    wrap. Closer wraps are out of scope and are not checked.
//  - Count arithmetic is CNT_W-bit unsigned; N_lat-1 is computed only when N_lat != 0.
//  - Reset=0 mid-burst forces the reset values above on the next edge; Wave_Gate drops
//    immediately on that edge.
// CONFIGURATION
//  BURST_INFINITE_EN defined:
//    - Burst_N==0 is accepted as an infinite burst: DELAY, then BURST with no count
//      termination; only Stop or Reset ends it.
//    - Cnt_EN pulses on every wrap; the counter wraps freely at 2^CNT_W. Done never pulses.
//  BURST_INFINITE_EN undefined:
//    - Burst_N==0 is rejected: Trig_Ign pulse, state stays IDLE.
// TESTING
//  1 N=3, delay=0, wrap every 8 clk, trigger edge at t
//    -> Cnt_Clr_n=0 at t+1; Wave_Gate=1 from t+3;
//    -> 3 Cnt_EN pulses, gate falls together with the 3rd pulse; Done when Sum_In=3; Busy=0.
//  2 delay=5, N=1 -> DELAY lasts 7 cycles; one Cnt_EN; Done once.
//  3 trigger edge at the 2nd wrap of an N=4 burst -> Trig_Ign pulse; burst still emits
//    4 cycles.
//  4 Stop asserted with the 2nd wrap of N=5 -> next cycle IDLE, gate 0, only 1 Cnt_EN,
//    no Done.
//  5 N=0 -> macro off: Trig_Ign pulse, Busy stays 0;
//    macro on: gate held 10 wraps until Stop, 10 Cnt_EN, no Done.
//  6 Reset=0 mid-BURST of N=8 -> all outputs at reset values next edge; new trigger
//    restarts cleanly.

Source files
------------

// File: rtl/burst_cycle_controller.sv
// -----------------------------------------------------------------------------
// burst_cycle_controller
//
// Burst-mode sequencer for the waveform generator. A rising edge on Trigger
// latches the burst length and trigger delay. The controller clears the
// external amount counter and waits out the delay. It then opens Wave_Gate for
// exactly Burst_N waveform cycles. Cycles are counted by pulsing Cnt_EN on each
// Cycle_Wrap and reading the counter back on Sum_In.
//
// Optional feature macro: BURST_INFINITE_EN
//   defined   : Burst_N == 0 starts an endless burst (only Stop/Reset end it)
//   undefined : Burst_N == 0 is rejected with a Trig_Ign pulse
//
// Parameters
//   CNT_W       burst count width (must match the amount counter)
//   DLY_W       trigger-delay counter width
//
// Ports
//   Clock       in   system clock, posedge
//   Reset       in   synchronous reset, active low
//   Trigger     in   burst trigger level; rising edge detected internally
//   Stop        in   abort request, active high
//   Burst_N     in   waveform cycles per burst, latched on trigger accept
//   Trig_Delay  in   extra delay cycles before gating, latched on accept
//   Cycle_Wrap  in   one-clock pulse per completed waveform cycle
//   Sum_In      in   amount counter SUM_OUT (2-clock latency from Cnt_EN)
//   Cnt_EN      out  counter increment pulse
//   Cnt_Clr_n   out  counter clear, active low
//   Wave_Gate   out  waveform output enable
//   Busy        out  controller not idle
//   Done        out  one-clock pulse on normal burst completion
//   Trig_Ign    out  one-clock pulse when a trigger edge is rejected
// -----------------------------------------------------------------------------
module burst_cycle_controller #(
    parameter int CNT_W = 20,
    parameter int DLY_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Trigger,
    input  logic             Stop,
    input  logic [CNT_W-1:0] Burst_N,
    input  logic [DLY_W-1:0] Trig_Delay,
    input  logic             Cycle_Wrap,
    input  logic [CNT_W-1:0] Sum_In,
    output logic             Cnt_EN,
    output logic             Cnt_Clr_n,
    output logic             Wave_Gate,
    output logic             Busy,
    output logic             Done,
    output logic             Trig_Ign
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_BURST = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic             prev_q,      prev_d;
    logic [CNT_W-1:0] n_lat_q,     n_lat_d;
    logic [DLY_W-1:0] dly_lat_q,   dly_lat_d;
    // One bit wider than the delay so that Trig_Delay+1 cannot overflow.
    logic [DLY_W:0]   dly_cnt_q,   dly_cnt_d;
    logic             cnt_en_q,    cnt_en_d;
    logic             cnt_clr_n_q, cnt_clr_n_d;
    logic             wave_gate_q, wave_gate_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             trig_ign_q,  trig_ign_d;

    logic             trig_edge;
    logic             accept_n;
    logic [CNT_W-1:0] n_minus_1;
    logic             last_wrap;

    always_comb begin
        state_d     = state_q;
        prev_d      = Trigger;
        n_lat_d     = n_lat_q;
        dly_lat_d   = dly_lat_q;
        dly_cnt_d   = dly_cnt_q;
        cnt_en_d    = 1'b0;
        cnt_clr_n_d = 1'b1;
        wave_gate_d = wave_gate_q;
        done_d      = 1'b0;
        trig_ign_d  = 1'b0;

        trig_edge = Trigger & ~prev_q;
`ifdef BURST_INFINITE_EN
        accept_n = 1'b1;
`else
        accept_n = (Burst_N != '0);
`endif
        // N_lat == 0 only occurs for an endless burst, which never terminates
        // on count, so the subtraction is guarded rather than allowed to wrap.
        n_minus_1 = (n_lat_q != '0) ? (n_lat_q - CNT_W'(1)) : '0;
        last_wrap = (n_lat_q != '0) && (Sum_In == n_minus_1);

        case (state_q)
            S_IDLE: begin
                if (trig_edge) begin
                    if (accept_n) begin
                        n_lat_d     = Burst_N;
                        dly_lat_d   = Trig_Delay;
                        dly_cnt_d   = '0;
                        cnt_clr_n_d = 1'b0;
                        state_d     = S_DELAY;
                    end else begin
                        trig_ign_d = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                // Two extra cycles let the cleared counter value reach Sum_In
                // before the first wrap can be counted.
                if (dly_cnt_q == ({1'b0, dly_lat_q} + (DLY_W+1)'(1))) begin
                    wave_gate_d = 1'b1;
                    state_d     = S_BURST;
                end else begin
                    dly_cnt_d = dly_cnt_q + (DLY_W+1)'(1);
                end
            end
            S_BURST: begin
                if (Cycle_Wrap) begin
                    cnt_en_d = 1'b1;
                    if (last_wrap) begin
                        wave_gate_d = 1'b0;
                        state_d     = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Wait for the final increment to appear on Sum_In.
                if (Sum_In == n_lat_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            if (trig_edge) begin
                trig_ign_d = 1'b1;
            end
            // Abort wins over any wrap or completion seen in the same cycle.
            if (Stop) begin
                state_d     = S_IDLE;
                wave_gate_d = 1'b0;
                cnt_en_d    = 1'b0;
                done_d      = 1'b0;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            prev_q      <= 1'b0;
            n_lat_q     <= '0;
            dly_lat_q   <= '0;
            dly_cnt_q   <= '0;
            cnt_en_q    <= 1'b0;
            cnt_clr_n_q <= 1'b1;
            wave_gate_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            trig_ign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            n_lat_q     <= n_lat_d;
            dly_lat_q   <= dly_lat_d;
            dly_cnt_q   <= dly_cnt_d;
            cnt_en_q    <= cnt_en_d;
            cnt_clr_n_q <= cnt_clr_n_d;
            wave_gate_q <= wave_gate_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            trig_ign_q  <= trig_ign_d;
        end
    end

    assign Cnt_EN    = cnt_en_q;
    assign Cnt_Clr_n = cnt_clr_n_q;
    assign Wave_Gate = wave_gate_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Trig_Ign  = trig_ign_q;

endmodule

// File: tb/tb_burst_cycle_controller.sv
// -----------------------------------------------------------------------------
// tb_burst_cycle_controller
//
// Directed scoreboard bench for burst_cycle_controller. Stimulus pushes the
// hand-computed output events (kind, cycle) into a time-ordered queue. A
// monitor on the falling edge detects every output event and pops/compares
// it against that queue. A behavioural amount counter with 2-clock latency
// closes the Cnt_EN -> Sum_In loop.
// -----------------------------------------------------------------------------
module tb_burst_cycle_controller;

    localparam int CNT_W = 20;
    localparam int DLY_W = 16;

    localparam int K_CLR    = 0;
    localparam int K_BUSY_R = 1;
    localparam int K_GATE_R = 2;
    localparam int K_EN     = 3;
    localparam int K_GATE_F = 4;
    localparam int K_DONE   = 5;
    localparam int K_BUSY_F = 6;
    localparam int K_IGN    = 7;

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic             Trigger = 1'b0;
    logic             Stop = 1'b0;
    logic [CNT_W-1:0] Burst_N = '0;
    logic [DLY_W-1:0] Trig_Delay = '0;
    logic             Cycle_Wrap = 1'b0;
    logic [CNT_W-1:0] Sum_In;
    logic             Cnt_EN, Cnt_Clr_n, Wave_Gate, Busy, Done, Trig_Ign;

    burst_cycle_controller #(.CNT_W(CNT_W), .DLY_W(DLY_W)) dut (
        .Clock(Clock), .Reset(Reset), .Trigger(Trigger), .Stop(Stop),
        .Burst_N(Burst_N), .Trig_Delay(Trig_Delay), .Cycle_Wrap(Cycle_Wrap),
        .Sum_In(Sum_In), .Cnt_EN(Cnt_EN), .Cnt_Clr_n(Cnt_Clr_n),
        .Wave_Gate(Wave_Gate), .Busy(Busy), .Done(Done), .Trig_Ign(Trig_Ign)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Amount counter: increment registered, then SUM_OUT registered again.
    logic [CNT_W-1:0] amt_cnt = '0;
    logic [CNT_W-1:0] amt_sum = '0;
    always @(posedge Clock) begin
        if (!(Cnt_Clr_n && Reset)) begin
            amt_cnt <= '0;
            amt_sum <= '0;
        end else begin
            if (Cnt_EN) amt_cnt <= amt_cnt + CNT_W'(1);
            amt_sum <= amt_cnt;
        end
    end
    assign Sum_In = amt_sum;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    function automatic string kname(int k);
        case (k)
            K_CLR:    return "CLR";
            K_BUSY_R: return "BUSY_RISE";
            K_GATE_R: return "GATE_RISE";
            K_EN:     return "CNT_EN";
            K_GATE_F: return "GATE_FALL";
            K_DONE:   return "DONE";
            K_BUSY_F: return "BUSY_FALL";
            default:  return "TRIG_IGN";
        endcase
    endfunction

    task automatic expect_ev(int kind, int c);
        ev_t e;
        int  i;
        e.kind = kind;
        e.cyc  = c;
        i = 0;
        while (i < exp_q.size() &&
               (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= kind)))
            i++;
        exp_q.insert(i, e);
    endtask

    // Monitor: report every output event in fixed kind order per cycle.
    logic gate_prev = 1'b0;
    logic busy_prev = 1'b0;
    always @(negedge Clock) begin
        logic [7:0] ev;
        ev = '0;
        ev[K_CLR]    = (Cnt_Clr_n === 1'b0);
        ev[K_BUSY_R] = (Busy === 1'b1) && !busy_prev;
        ev[K_GATE_R] = (Wave_Gate === 1'b1) && !gate_prev;
        ev[K_EN]     = (Cnt_EN === 1'b1);
        ev[K_GATE_F] = (Wave_Gate === 1'b0) && gate_prev;
        ev[K_DONE]   = (Done === 1'b1);
        ev[K_BUSY_F] = (Busy === 1'b0) && busy_prev;
        ev[K_IGN]    = (Trig_Ign === 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (ev[k]) begin
                ev_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: got %s at cyc %0d, required none",
                             kname(k), cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != k || e.cyc != cyc) begin
                        failures++;
                        $display("FAIL event_order: got %s at cyc %0d, required %s at cyc %0d",
                                 kname(k), cyc, kname(e.kind), e.cyc);
                    end
                end
            end
        end
        gate_prev = (Wave_Gate === 1'b1);
        busy_prev = (Busy === 1'b1);
    end

    task automatic run_to(int c);
        while (cyc < c) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic wrap_at(int c);
        run_to(c);
        Cycle_Wrap = 1'b1;
        run_to(c + 1);
        Cycle_Wrap = 1'b0;
    endtask

    task automatic trig_at(int c, int n, int d);
        run_to(c);
        Trigger    = 1'b1;
        Burst_N    = CNT_W'(n);
        Trig_Delay = DLY_W'(d);
        run_to(c + 1);
        Trigger    = 1'b0;
        Burst_N    = CNT_W'(7);   // later changes must not affect the burst
        Trig_Delay = DLY_W'(9);
    endtask

    task automatic end_test(string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing: pending=%0d first=%s@%0d, required 0 pending",
                     name, exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic chk(string name, logic act, logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_cnt_en"},    Cnt_EN,    1'b0);
        chk({tag, "_cnt_clr_n"}, Cnt_Clr_n, 1'b1);
        chk({tag, "_wave_gate"}, Wave_Gate, 1'b0);
        chk({tag, "_busy"},      Busy,      1'b0);
        chk({tag, "_done"},      Done,      1'b0);
        chk({tag, "_trig_ign"},  Trig_Ign,  1'b0);
    endtask

    initial begin
        int b;

        // Reset state
        run_to(3);
        @(negedge Clock);
        chk_reset_outputs("reset");
        Reset = 1'b1;
        run_to(6);

        // 1: N=3, delay 0, wraps every 8 clocks
        b = cyc + 2;
        expect_ev(K_CLR, b + 1);   expect_ev(K_BUSY_R, b + 1);
        expect_ev(K_GATE_R, b + 3);
        expect_ev(K_EN, b + 5);    expect_ev(K_EN, b + 13);
        expect_ev(K_EN, b + 21);   expect_ev(K_GATE_F, b + 21);
        expect_ev(K_DONE, b + 24); expect_ev(K_BUSY_F, b + 24);
        trig_at(b, 3, 0);
        wrap_at(b + 4); wrap_at(b + 12); wrap_at(b + 20);
        run_to(b + 30);
        end_test("t1");

        // 2: delay 5, N=1 -> DELAY spans 7 cycles
        b = cyc + 2;
        expect_ev(K_CLR, b + 1);   expect_ev(K_BUSY_R, b + 1);
        expect_ev(K_GATE_R, b + 8);
        expect_ev(K_EN, b + 10);   expect_ev(K_GATE_F, b + 10);
        expect_ev(K_DONE, b + 13); expect_ev(K_BUSY_F, b + 13);
        trig_at(b, 1, 5);
        wrap_at(b + 9);
        run_to(b + 20);
        end_test("t2");

        // 3: trigger edge at the 2nd wrap of an N=4 burst is ignored
        b = cyc + 2;
        expect_ev(K_CLR, b + 1);   expect_ev(K_BUSY_R, b + 1);
        expect_ev(K_GATE_R, b + 3);
        expect_ev(K_EN, b + 5);    expect_ev(K_EN, b + 11);
        expect_ev(K_IGN, b + 11);
        expect_ev(K_EN, b + 17);   expect_ev(K_EN, b + 23);
        expect_ev(K_GATE_F, b + 23);
        expect_ev(K_DONE, b + 26); expect_ev(K_BUSY_F, b + 26);
        trig_at(b, 4, 0);
        wrap_at(b + 4);
        run_to(b + 10);
        Trigger = 1'b1; Cycle_Wrap = 1'b1;
        run_to(b + 11);
        Trigger = 1'b0; Cycle_Wrap = 1'b0;
        wrap_at(b + 16); wrap_at(b + 22);
        run_to(b + 32);
        end_test("t3");

        // 4: Stop together with the 2nd wrap of N=5
        b = cyc + 2;
        expect_ev(K_CLR, b + 1);   expect_ev(K_BUSY_R, b + 1);
        expect_ev(K_GATE_R, b + 3);
        expect_ev(K_EN, b + 5);
        expect_ev(K_GATE_F, b + 11); expect_ev(K_BUSY_F, b + 11);
        trig_at(b, 5, 0);
        wrap_at(b + 4);
        run_to(b + 10);
        Stop = 1'b1; Cycle_Wrap = 1'b1;
        run_to(b + 11);
        Stop = 1'b0; Cycle_Wrap = 1'b0;
        wrap_at(b + 14);
        run_to(b + 22);
        end_test("t4");

        // 5: N=0
        b = cyc + 2;
`ifdef BURST_INFINITE_EN
        expect_ev(K_CLR, b + 1);   expect_ev(K_BUSY_R, b + 1);
        expect_ev(K_GATE_R, b + 3);
        for (int i = 0; i < 10; i++) expect_ev(K_EN, b + 5 + 6 * i);
        expect_ev(K_GATE_F, b + 63); expect_ev(K_BUSY_F, b + 63);
        trig_at(b, 0, 0);
        for (int i = 0; i < 10; i++) wrap_at(b + 4 + 6 * i);
        run_to(b + 62);
        Stop = 1'b1;
        run_to(b + 63);
        Stop = 1'b0;
        run_to(b + 70);
`else
        expect_ev(K_IGN, b + 1);
        trig_at(b, 0, 0);
        wrap_at(b + 4);
        run_to(b + 10);
`endif
        end_test("t5");

        // 6: Reset mid-burst of N=8, then a clean restart
        b = cyc + 2;
        expect_ev(K_CLR, b + 1);   expect_ev(K_BUSY_R, b + 1);
        expect_ev(K_GATE_R, b + 3);
        expect_ev(K_EN, b + 5);    expect_ev(K_EN, b + 11);
        expect_ev(K_GATE_F, b + 14); expect_ev(K_BUSY_F, b + 14);
        trig_at(b, 8, 0);
        wrap_at(b + 4); wrap_at(b + 10);
        run_to(b + 13);
        Reset = 1'b0;
        run_to(b + 14);
        @(negedge Clock);
        chk_reset_outputs("midreset");
        Reset = 1'b1;
        expect_ev(K_CLR, b + 17);  expect_ev(K_BUSY_R, b + 17);
        expect_ev(K_GATE_R, b + 20);
        expect_ev(K_EN, b + 22);
        expect_ev(K_EN, b + 28);   expect_ev(K_GATE_F, b + 28);
        expect_ev(K_DONE, b + 31); expect_ev(K_BUSY_F, b + 31);
        trig_at(b + 16, 2, 1);
        wrap_at(b + 21); wrap_at(b + 27);
        run_to(b + 38);
        end_test("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
